// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and the logic that accesses it.
package imem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_FETCH  = 2'd1,
        OWN_LOADER = 2'd2
    } owner_t;

    localparam int IMEM_DEPTH = 17;
    localparam int IMEM_IDX_W = 5;

    // A byte address names a whole instruction word only when its two LSBs are zero.
    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/imem_addr_check.sv
// Converts a byte address to a word index and flags misaligned or out-of-range accesses.
module imem_addr_check
    import imem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int IDX_W  = IMEM_IDX_W
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              fault
);

    logic [ADDR_W-1:0] word;

    assign word  = addr >> 2;
    assign idx   = word[IDX_W-1:0];
    assign fault = !word_aligned(addr[1:0]) || (word >= ADDR_W'(DEPTH));

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between fetch and loader, one access per cycle,
// steering the one-cycle-late read data back to the port that issued the read.
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DEPTH         = IMEM_DEPTH,
    parameter int IDX_W         = IMEM_IDX_W,
    parameter int MAX_FETCH_RUN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    input  logic              ld_hold,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [31:0]       ld_rdata,
    output logic              addr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [IDX_W-1:0]  mem_idx,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [7:0] RUN_MAX = 8'(MAX_FETCH_RUN);

    logic [7:0]        run_cnt;
    owner_t            resp_owner;
    logic              resp_fault;
    logic [31:0]       f_rdata_q;
    logic [31:0]       ld_rdata_q;
    logic [31:0]       resp_data;
    logic [ADDR_W-1:0] acc_addr;
    logic [IDX_W-1:0]  acc_idx;
    logic              acc_fault;
    logic              acc_any;

    // Grants are forced low during reset so every output reads zero while rst is high.
    always_comb begin
        f_gnt  = 1'b0;
        ld_gnt = 1'b0;
        if (!rst) begin
            if (ld_hold) begin
                ld_gnt = ld_req;
            end else if (f_req && ld_req) begin
                if (run_cnt == RUN_MAX) ld_gnt = 1'b1;
                else                    f_gnt  = 1'b1;
            end else begin
                f_gnt  = f_req;
                ld_gnt = ld_req;
            end
        end
    end

    assign acc_addr = ld_gnt ? ld_addr : f_addr;
    assign acc_any  = f_gnt | ld_gnt;

    imem_addr_check #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_addr_check (
        .addr  (acc_addr),
        .idx   (acc_idx),
        .fault (acc_fault)
    );

    // A faulting access keeps its grant but never reaches the array.
    assign mem_en    = acc_any & ~acc_fault;
    assign mem_we    = mem_en & ld_gnt & ld_we;
    assign mem_idx   = mem_en ? acc_idx : '0;
    assign mem_wdata = mem_we ? ld_wdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt    <= '0;
            resp_owner <= OWN_NONE;
            resp_fault <= 1'b0;
            addr_err   <= 1'b0;
            f_rdata_q  <= '0;
            ld_rdata_q <= '0;
        end else begin
            if (ld_gnt || !ld_req)
                run_cnt <= '0;
            else if (f_gnt && run_cnt != RUN_MAX)
                run_cnt <= run_cnt + 8'd1;

            if (f_gnt)                resp_owner <= OWN_FETCH;
            else if (ld_gnt && !ld_we) resp_owner <= OWN_LOADER;
            else                       resp_owner <= OWN_NONE;

            resp_fault <= acc_fault;
            addr_err   <= acc_any & acc_fault;

            if (resp_owner == OWN_FETCH)  f_rdata_q  <= resp_data;
            if (resp_owner == OWN_LOADER) ld_rdata_q <= resp_data;
        end
    end

    // The owning port sees the array output live; the other port keeps its last word.
    assign resp_data = resp_fault ? '0 : mem_rdata;
    assign f_rvalid  = resp_owner == OWN_FETCH;
    assign ld_rvalid = resp_owner == OWN_LOADER;
    assign f_rdata   = f_rvalid  ? resp_data : f_rdata_q;
    assign ld_rdata  = ld_rvalid ? resp_data : ld_rdata_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed and randomized checks of imem_port_arbiter against a cycle-level reference model.
module tb_imem_port_arbiter;

    localparam int MAXRUN = 8;
    localparam int DEPTH  = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        f_req, ld_hold, ld_req, ld_we;
    logic [31:0] f_addr, ld_addr, ld_wdata;
    logic        f_gnt, f_rvalid, ld_gnt, ld_rvalid, addr_err, mem_en, mem_we;
    logic [31:0] f_rdata, ld_rdata, mem_wdata, mem_rdata;
    logic [4:0]  mem_idx;

    int total = 0;
    int bad   = 0;

    imem_port_arbiter #(
        .ADDR_W(32), .DEPTH(DEPTH), .IDX_W(5), .MAX_FETCH_RUN(MAXRUN)
    ) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .ld_hold(ld_hold), .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .addr_err(addr_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read single-port array driven only by the DUT.
    logic [31:0] ram [0:31];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_idx] <= mem_wdata;
            else        mem_rdata    <= ram[mem_idx];
        end
    end

    // Reference model state: memory image, fetch streak, and the one outstanding read.
    logic [31:0] ref_mem [0:DEPTH-1];
    int          m_run;
    int          m_pend;      // 0 none, 1 fetch, 2 loader
    logic [31:0] m_pend_dat;
    logic        m_err;
    logic [31:0] m_frd, m_lrd;

    logic        o_fg, o_lg, o_en, o_we, o_frv, o_lrv, o_err;
    logic [31:0] o_frd, o_lrd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_run = 0; m_pend = 0; m_pend_dat = '0; m_err = 1'b0; m_frd = '0; m_lrd = '0;
    endtask

    task automatic step();
        logic        e_fg, e_lg, e_flt, e_en, e_we;
        logic [31:0] a;
        int          widx;
        @(negedge clk);
        if (rst) m_reset();
        e_fg = 1'b0;
        e_lg = 1'b0;
        if (!rst) begin
            if (ld_hold) e_lg = ld_req;
            else if (f_req && ld_req) begin
                e_lg = (m_run >= MAXRUN);
                e_fg = !e_lg;
            end else begin
                e_fg = f_req;
                e_lg = ld_req;
            end
        end
        a     = e_lg ? ld_addr : f_addr;
        e_flt = (e_fg || e_lg) && ((a % 4) != 0 || (a / 4) >= DEPTH);
        e_en  = (e_fg || e_lg) && !e_flt;
        e_we  = e_en && e_lg && ld_we;
        widx  = e_en ? int'(a / 4) : 0;

        o_fg = f_gnt;  o_lg = ld_gnt;  o_en = mem_en; o_we = mem_we;
        o_frv = f_rvalid; o_frd = f_rdata; o_lrv = ld_rvalid; o_lrd = ld_rdata; o_err = addr_err;

        chk("f_gnt", f_gnt, e_fg);
        chk("ld_gnt", ld_gnt, e_lg);
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_we);
        if (e_en) chk("mem_idx", mem_idx, widx);
        if (e_we) chk("mem_wdata", mem_wdata, ld_wdata);
        if (rst) begin
            chk("rst_mem_idx", mem_idx, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
        end
        chk("f_rvalid", f_rvalid, m_pend == 1);
        chk("ld_rvalid", ld_rvalid, m_pend == 2);
        chk("f_rdata", f_rdata, (m_pend == 1) ? m_pend_dat : m_frd);
        chk("ld_rdata", ld_rdata, (m_pend == 2) ? m_pend_dat : m_lrd);
        chk("addr_err", addr_err, m_err);

        if (!rst) begin
            if (m_pend == 1) m_frd = m_pend_dat;
            if (m_pend == 2) m_lrd = m_pend_dat;
            m_err = e_flt;
            if (e_fg)                m_pend = 1;
            else if (e_lg && !ld_we) m_pend = 2;
            else                     m_pend = 0;
            m_pend_dat = e_flt ? 32'h0 : ref_mem[widx];
            if (e_we) ref_mem[widx] = ld_wdata;
            if (e_lg || !ld_req) m_run = 0;
            else if (e_fg && m_run < MAXRUN) m_run = m_run + 1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 32'(4 * $urandom_range(0, DEPTH - 1));
        else if (r == 7) return 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
        else if (r == 8) return 32'(4 * $urandom_range(DEPTH, DEPTH + 3));
        else             return $urandom;
    endfunction

    initial begin
        m_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        f_req = 1'b1; f_addr = '0; ld_hold = 1'b0; ld_req = 1'b1; ld_we = 1'b0;
        ld_addr = '0; ld_wdata = '0;
        #1 rst = 1'b1;
        step();
        chk("rst_f_gnt", o_fg, 0);
        chk("rst_addr_err", o_err, 0);
        rst = 1'b0;
        f_req = 1'b0; ld_req = 1'b0;
        step();

        // Preload the array through the loader port.
        for (int i = 0; i < DEPTH; i++) begin
            ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'(4 * i);
            ld_wdata = (i == 0) ? 32'h9000_9089 : (i == 1) ? 32'h9000_A089 : (i == 2) ? 32'h0 : $urandom;
            step();
        end
        ld_req = 1'b0; ld_we = 1'b0;
        step();

        // Back-to-back fetch reads.
        f_req = 1'b1; f_addr = 32'h0; step();
        chk("fetch0_gnt", o_fg, 1);
        f_addr = 32'h4; step();
        chk("fetch1_rv", o_frv, 1); chk("fetch1_rd", o_frd, 32'h9000_9089);
        f_addr = 32'h8; step();
        chk("fetch2_rv", o_frv, 1); chk("fetch2_rd", o_frd, 32'h9000_A089);
        f_req = 1'b0; step();
        chk("fetch3_rv", o_frv, 1); chk("fetch3_rd", o_frd, 32'h0);
        step();
        chk("fetch_idle_rv", o_frv, 0);

        // Loader starvation bound.
        f_req = 1'b1; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h10;
        for (int i = 0; i < 10; i++) begin
            f_addr = 32'(4 * i);
            step();
            chk("starve_f", o_fg, i != 8);
            chk("starve_ld", o_lg, i == 8);
        end
        f_req = 1'b0; ld_req = 1'b0; step();

        // Loader exclusive hold: write then read back.
        ld_hold = 1'b1; f_req = 1'b1; f_addr = 32'h0;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h2C; ld_wdata = 32'h5569_B021;
        step();
        chk("hold_wr_f", o_fg, 0); chk("hold_wr_ld", o_lg, 1); chk("hold_wr_we", o_we, 1);
        ld_we = 1'b0; step();
        chk("hold_rd_f", o_fg, 0); chk("hold_rd_ld", o_lg, 1);
        ld_req = 1'b0; step();
        chk("hold_rv", o_lrv, 1); chk("hold_rd", o_lrd, 32'h5569_B021); chk("hold_f3", o_fg, 0);
        ld_hold = 1'b0; f_req = 1'b0; step();

        // Faulting accesses.
        f_req = 1'b1; f_addr = 32'h6; step();
        chk("mis_gnt", o_fg, 1); chk("mis_en", o_en, 0);
        f_req = 1'b0; step();
        chk("mis_err", o_err, 1); chk("mis_rv", o_frv, 1); chk("mis_rd", o_frd, 0);
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h44; ld_wdata = 32'hDEAD_BEEF; step();
        chk("oor_gnt", o_lg, 1); chk("oor_en", o_en, 0);
        ld_req = 1'b0; ld_we = 1'b0; step();
        chk("oor_err", o_err, 1); chk("oor_rv", o_lrv, 0);
        step();
        chk("err_clear", o_err, 0);

        // Response steering between the two ports.
        f_req = 1'b1; f_addr = 32'h4; step();
        f_req = 1'b0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h2C; step();
        chk("steer1_frv", o_frv, 1); chk("steer1_lrv", o_lrv, 0); chk("steer1_frd", o_frd, 32'h9000_A089);
        ld_req = 1'b0; step();
        chk("steer2_frv", o_frv, 0); chk("steer2_lrv", o_lrv, 1);
        chk("steer2_lrd", o_lrd, 32'h5569_B021); chk("steer2_fhold", o_frd, 32'h9000_A089);

        // Reset while a fetch read is in flight.
        f_req = 1'b1; f_addr = 32'h0; step();
        f_req = 1'b0; rst = 1'b1; step();
        chk("midrst_frv", o_frv, 0); chk("midrst_frd", o_frd, 0);
        rst = 1'b0; step();
        chk("postrst_frv", o_frv, 0);

        // Randomized traffic; each requester holds its request until granted.
        f_req = 1'b0; ld_req = 1'b0;
        for (int n = 0; n < 600; n++) begin
            step();
            if (!(f_req && !o_fg)) begin
                f_req  = $urandom_range(0, 3) != 0;
                f_addr = rand_addr();
            end
            if (!(ld_req && !o_lg)) begin
                ld_req   = $urandom_range(0, 2) == 0;
                ld_we    = $urandom_range(0, 1) == 1;
                ld_addr  = rand_addr();
                ld_wdata = $urandom;
            end
            if ($urandom_range(0, 15) == 0) ld_hold = !ld_hold;
        end
        f_req = 1'b0; ld_req = 1'b0; ld_hold = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
